// File: rtl/scancode_decoder.sv
// PS/2 set-2 scancode decoder: collapses E0/F0 prefix sequences into key events
// and queues them in a first-word-fall-through FIFO.
module scancode_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SCANCODE,
    input  logic       DVALID,
    input  logic       RD_EN,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVF
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Bytes that carry no key meaning when seen outside a prefix (ack, BAT, echo, errors).
    function automatic logic isIgnored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    function automatic logic isFakeShift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    logic             dvalidQ_r;
    logic             armed_r;
    logic             strobe_s;
    state_t           state_r;
    state_t           nextState_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] nextTimer_s;
    logic             pushReq_s;
    logic             pushExt_s;
    logic             pushBrk_s;

    logic [9:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] nextCount_s;
    logic             pop_s;
    logic             pushAcc_s;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;

    // armed_r blocks a strobe from a DVALID that was already high when reset released.
    assign strobe_s = DVALID & ~dvalidQ_r & armed_r;

    // DVALID edge-detect register and post-reset arming.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dvalidQ_r <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            dvalidQ_r <= DVALID;
            if (!DVALID) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Prefix state and timeout counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            timer_r <= '0;
        end else begin
            state_r <= nextState_s;
            timer_r <= nextTimer_s;
        end
    end

    // Prefix decode, event generation and timeout.
    always_comb begin
        nextState_s = state_r;
        nextTimer_s = timer_r;
        pushReq_s   = 1'b0;
        pushExt_s   = 1'b0;
        pushBrk_s   = 1'b0;
        if (strobe_s) begin
            nextTimer_s = '0;
            case (state_r)
                IDLE: begin
                    if (SCANCODE == 8'hE0) begin
                        nextState_s = EXT;
                    end else if (SCANCODE == 8'hF0) begin
                        nextState_s = BRK;
                    end else if (isIgnored(SCANCODE)) begin
                        nextState_s = IDLE;
                    end else begin
                        pushReq_s = 1'b1;
                    end
                end
                EXT: begin
                    if (SCANCODE == 8'hE0) begin
                        nextState_s = EXT;
                    end else if (SCANCODE == 8'hF0) begin
                        nextState_s = EXT_BRK;
                    end else if (isFakeShift(SCANCODE)) begin
                        nextState_s = IDLE;
                    end else begin
                        pushReq_s   = 1'b1;
                        pushExt_s   = 1'b1;
                        nextState_s = IDLE;
                    end
                end
                BRK: begin
                    if (SCANCODE == 8'hF0) begin
                        nextState_s = BRK;
                    end else if (SCANCODE == 8'hE0) begin
                        nextState_s = EXT_BRK;
                    end else begin
                        pushReq_s   = 1'b1;
                        pushBrk_s   = 1'b1;
                        nextState_s = IDLE;
                    end
                end
                EXT_BRK: begin
                    if ((SCANCODE == 8'hE0) || (SCANCODE == 8'hF0)) begin
                        nextState_s = EXT_BRK;
                    end else if (isFakeShift(SCANCODE)) begin
                        nextState_s = IDLE;
                    end else begin
                        pushReq_s   = 1'b1;
                        pushExt_s   = 1'b1;
                        pushBrk_s   = 1'b1;
                        nextState_s = IDLE;
                    end
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end else if (state_r != IDLE) begin
            if (timer_r == TMR_LAST) begin
                nextState_s = IDLE;
                nextTimer_s = '0;
            end else begin
                nextTimer_s = timer_r + TMR_W'(1);
            end
        end else begin
            nextTimer_s = '0;
        end
    end

    assign pop_s     = RD_EN & (count_r != '0);
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pushAcc_s = pushReq_s & ((count_r != CNT_FULL) | pop_s);

    // Occupancy update.
    always_comb begin
        nextCount_s = count_r;
        case ({pushAcc_s, pop_s})
            2'b10:   nextCount_s = count_r + CNT_W'(1);
            2'b01:   nextCount_s = count_r - CNT_W'(1);
            default: nextCount_s = count_r;
        endcase
    end

    // FIFO storage, pointers, flags and sticky overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (pushAcc_s) begin
                mem_r[wrPtr_r] <= {pushExt_s, pushBrk_s, SCANCODE};
                wrPtr_r        <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            if (pushReq_s && !pushAcc_s) begin
                ovf_r <= 1'b1;
            end
            count_r <= nextCount_s;
            empty_r <= (nextCount_s == '0);
            full_r  <= (nextCount_s == CNT_FULL);
        end
    end

    assign EV_EXT   = empty_r ? 1'b0  : mem_r[rdPtr_r][9];
    assign EV_BREAK = empty_r ? 1'b0  : mem_r[rdPtr_r][8];
    assign EV_CODE  = empty_r ? 8'h00 : mem_r[rdPtr_r][7:0];
    assign EMPTY    = empty_r;
    assign FULL     = full_r;
    assign OVF      = ovf_r;
endmodule
